sram_ctrl: RTL and testbench

Multi-cycle data-memory controller in the MEM stage. Accepts the ALU-computed address and store data, performs 32-bit reads and writes as two 16-bit external SRAM accesses, and returns the load value that the write-back stage selects when `mem_read_en` is set. While an access is in flight it deasserts `ready`; the hazard/freeze logic stalls every upstream pipeline register on `~ready`.

---
 rtl/sram_ctrl.sv | 135 +++++++++++++
 tb/tb_sram_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: MEM-stage data-memory controller. Each 32-bit load or store is
// split into two 16-bit SRAM accesses, low halfword first. Each access lasts
// PHASE_CYCLES cycles. `ready` stays low while an access is in flight.
// Optional feature: define SRAM_CTRL_RANGE_CHECK_EN to complete requests that
// fall outside the SRAM window at once, with no SRAM strobes. Such loads return 0.
module sram_ctrl #(
  parameter int unsigned BASE_ADDR    = 1024,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int unsigned CntW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            write_q, write_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     offset;
  logic            unused_offset;

  assign offset = addr_q - BASE_ADDR;
  // Bits above the 512 KiB window and the byte-lane bits never reach the SRAM.
  assign unused_offset = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_CTRL_RANGE_CHECK_EN
  logic [31:0] req_offset;
  logic        req_oor;
  assign req_offset = address - BASE_ADDR;
  assign req_oor    = (address < BASE_ADDR) | (req_offset >= 32'h0008_0000);
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: request capture, phase counting and load-data sampling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (wr_en | rd_en) begin
          addr_d  = address;
          wdata_d = write_data;
          write_d = wr_en;
          cnt_d   = '0;
          state_d = StLow;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
          if (req_oor) begin
            state_d = StDone;
            if (!wr_en) rdata_d = '0;
          end
`endif
        end
      end
      StLow: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = StHigh;
          if (!write_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!write_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM bus outputs are driven only during the two access phases.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state_q == StLow || state_q == StHigh) begin
      sram_addr = {offset[18:2], state_q == StHigh};
      if (write_q) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  assign read_data = rdata_q;
  assign ready     = (state_q == StDone) | ((state_q == StIdle) & ~rd_en & ~wr_en);

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl. A behavioural SRAM sits on the bus.
// Expected load results go into a queue when the request is driven.
// Each result is popped and compared in the DONE cycle.
module tb_sram_ctrl;

  localparam int unsigned Base = 1024;
  localparam int unsigned P    = 2;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  logic [15:0] sram   [1024];
  logic [15:0] shadow [1024];
  logic [31:0] exp_q  [$];
  logic [31:0] rd_hold;
  int          n_checks;
  int          n_fail;
  logic        unused_hi;

  sram_ctrl #(
    .BASE_ADDR   (Base),
    .PHASE_CYCLES(P)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read, write on clock edge while we_n is low.
  assign sram_dq_in = sram[sram_addr[9:0]];
  assign unused_hi  = ^sram_addr[17:10];
  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr[9:0]] <= sram_dq_out;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] hw_addr(input logic [31:0] a, input logic h);
    logic [31:0] off;
    off = a - Base;
    return {off[18:2], h};
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    bit oor;
    oor = 1'b0;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    oor = (a < Base) || ((a - Base) >= 32'h0008_0000);
`endif
    return oor;
  endfunction

  // One request held from cycle 0 until its DONE cycle, checked every cycle.
  task automatic do_op(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] wd);
    bit          oor;
    int          last;
    logic        h;
    logic [17:0] lo, hi;
    logic [31:0] exp;
    oor = out_of_range(a);
    lo  = hw_addr(a, 1'b0);
    hi  = hw_addr(a, 1'b1);
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = wd;
    if (w) begin
      if (!oor) begin
        shadow[lo[9:0]] = wd[15:0];
        shadow[hi[9:0]] = wd[31:16];
      end
    end else begin
      exp_q.push_back(oor ? 32'h0 : {shadow[hi[9:0]], shadow[lo[9:0]]});
    end
    #1 check_eq("ready_cycle0", {31'b0, ready}, 32'd0);
    last = oor ? 1 : 2 * P + 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c < last) begin
        h = (c > P);
        check_eq($sformatf("sram_addr_c%0d", c), {14'b0, sram_addr}, {14'b0, h ? hi : lo});
        check_eq($sformatf("we_n_c%0d", c), {31'b0, sram_we_n}, {31'b0, ~w});
        check_eq($sformatf("oe_c%0d", c), {31'b0, sram_dq_oe}, {31'b0, w});
        if (w) check_eq($sformatf("dq_out_c%0d", c), {16'b0, sram_dq_out},
                        {16'b0, h ? wd[31:16] : wd[15:0]});
        check_eq($sformatf("ready_c%0d", c), {31'b0, ready}, 32'd0);
      end else begin
        check_eq("ready_done", {31'b0, ready}, 32'd1);
        check_eq("we_n_done", {31'b0, sram_we_n}, 32'd1);
        check_eq("oe_done", {31'b0, sram_dq_oe}, 32'd0);
        check_eq("sram_addr_done", {14'b0, sram_addr}, 32'd0);
        if (!w) begin
          if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
          end else begin
            exp = exp_q.pop_front();
            check_eq("load_data", read_data, exp);
            rd_hold = exp;
          end
        end else begin
          check_eq("read_data_held", read_data, rd_hold);
        end
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    n_checks = 0; n_fail = 0; rd_hold = '0;
    for (int i = 0; i < 1024; i++) begin
      sram[i]   = 16'(i * 16'h1357 + 16'h0042);
      shadow[i] = 16'(i * 16'h1357 + 16'h0042);
    end
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'b0, ready}, 32'd1);
    check_eq("rst_read_data", read_data, 32'd0);
    check_eq("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    check_eq("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
    check_eq("rst_sram_addr", {14'b0, sram_addr}, 32'd0);
    check_eq("rst_dq_out", {16'b0, sram_dq_out}, 32'd0);
    rst_n = 1'b1;

    do_op(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    check_eq("load_1028_const", read_data, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, 32'd1036, 32'h1234_5678);
    check_eq("held_after_store", read_data, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b1, 32'd1040, 32'hCAFE_F00D);
    check_eq("held_after_both", read_data, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 32'd1040, 32'h0);
    check_eq("load_1040_const", read_data, 32'hCAFE_F00D);
    do_op(1'b0, 1'b1, 32'h0000_0100, 32'h0);
    do_op(1'b0, 1'b1, 32'd1036, 32'h0);

    for (int k = 0; k < 6; k++) begin
      a = Base + 4 * $urandom_range(0, 200) + $urandom_range(0, 3);
      d = $urandom;
      do_op(1'b1, 1'b0, a, d);
      do_op(1'b0, 1'b1, a, 32'h0);
    end

    // Reset asserted during cycle 2 of a store aborts the access.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd2000; write_data = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_we_n", {31'b0, sram_we_n}, 32'd1);
    check_eq("abort_oe", {31'b0, sram_dq_oe}, 32'd0);
    check_eq("abort_sram_addr", {14'b0, sram_addr}, 32'd0);
    check_eq("abort_read_data", read_data, 32'd0);
    wr_en = 1'b0; rst_n = 1'b1;
    #1 check_eq("abort_ready", {31'b0, ready}, 32'd1);
    rd_hold = '0;
    @(negedge clk);
    check_eq("abort_idle_we_n", {31'b0, sram_we_n}, 32'd1);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    check_eq("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
